ir_fetch_unit: RTL and testbench
================================

Name: ir_fetch_unit

Overview:
- Instruction-side producer of IROut for the stage-4 datapath: fetches 16-bit words from instruction memory, buffers them in a small prefetch FIFO, and loads the instruction register when the control unit asserts IRWrite.
- Handles PC redirects (branch/jump) by flushing the buffer and discarding any in-flight memory response.
- Sits between instruction memory and the control unit/shifter/extender stage.

Parameters:
- ADDR_W, 16, instruction address width.
- DATA_W, 16, instruction word width.
- DEPTH, 2, prefetch FIFO entries (power of two, ≥2).
- RESET_PC, 16'h0000, first fetch address after reset.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- MemAddr  out  ADDR_W  fetch address, valid while MemReq=1.
- MemReq  out  1  fetch request; one outstanding maximum.
- MemAck  in  1  response valid; exactly one per accepted request, ≥1 cycle after request.
- MemRdData  in  DATA_W  instruction word, valid with MemAck.
- IRWrite  in  1  control unit consumes next instruction.
- Redirect  in  1  PC redirect (taken branch/jump).
- RedirectAddr  in  ADDR_W  new fetch address.
- IROut  out  DATA_W  current instruction register.
- PCOut  out  ADDR_W  address of the instruction in IROut.
- IRValid  out  1  IROut holds a fetched instruction.
- Stall  out  1  IRWrite seen with FIFO empty (combinational).

Behaviour:
- Reset (async, RST_N=0): IROut=0, PCOut=0, IRValid=0, MemReq=0, MemAddr=RESET_PC, FIFO empty, FetchPC=RESET_PC, state IDLE. Reset mid-transaction abandons the outstanding request. Any MemAck arriving after reset deasserts is ignored unless a new request is pending.
- FSM states:
  - IDLE: assert MemReq with MemAddr=FetchPC when (FIFO count + 0) < DEPTH; the request is accepted in the same cycle; next state WAIT.
  - WAIT: MemReq=0. On MemAck, push {FetchPC, MemRdData}, FetchPC<=FetchPC+1 (wraps 16'hFFFF->0), return to IDLE.
  - DROP: an outstanding response must be discarded. On MemAck, discard it; next state IDLE.
- Request gating: no request is issued while count==DEPTH. A slot is reserved for the outstanding word, so the issue condition is count+outstanding<DEPTH.
- IRWrite with FIFO non-empty: at the edge, IROut<=head data, PCOut<=head addr, IRValid<=1, pop. Latency from MemAck to IROut availability is ≥1 cycle (push then pop on a later edge). Same-cycle push+pop is legal when count≥1; count is unchanged.
- IRWrite with FIFO empty: Stall=1, IROut/PCOut/IRValid hold. Bypass from MemAck straight to IR is not supported.
- Redirect (wins over IRWrite and MemAck in the same cycle):
  - FIFO cleared.
  - FetchPC<=RedirectAddr.
  - IRValid<=0; IROut/PCOut hold.
  - If in WAIT without MemAck that cycle, go to DROP; otherwise go to IDLE.
  - Redirect while in DROP: remain in DROP, update FetchPC.
- MemAck in IDLE (protocol error): ignored.

Optional Feature:
- IR_IMM_DECODE_EN:
  - When defined, three registered outputs are added, updated on the same edge as IROut and reset to 0:
    - ImmZext[15:0] = {4'b0, IR[11:0]}
    - ImmSext[15:0] = {{4{IR[11]}}, IR[11:0]}
    - ShiftOp[1:0]: 01 for opcode 4'b1000 (SLL), 10 for 4'b1001 (SRL), 11 for 4'b1010 (SRA), 00 otherwise.
  - When undefined, these ports and registers are absent.

Decomposition:
- Shared package jala_pkg holds:
  - opcode constants OP_SLL=4'b1000, OP_SRL=4'b1001, OP_SRA=4'b1010;
  - the fetch FSM state typedef (IDLE, WAIT, DROP);
  - the fetch-entry struct {addr, data}.
- One sub-module, fetch_fifo (parameterised DEPTH, synchronous push/pop/clear, count output, async active-low reset); the FSM and IR register stay in the top.

Test Plan:
- Reset release, memory returns 16'h8003 at 0 and 16'h9005 at 1 with 2-cycle latency, IRWrite pulsed when data is available -> IROut=8003/PCOut=0, then IROut=9005/PCOut=1, IRValid=1, Stall never asserted.
- IRWrite held high from reset with 3-cycle memory latency -> Stall=1 until the first push; IROut stays 0 until the edge after the first word is buffered.
- FIFO fill: IRWrite=0 for 20 cycles -> exactly DEPTH=2 requests issued (addresses 0,1), MemReq stays 0 afterwards.
- Redirect to 16'h0040 while a request for address 2 is outstanding -> returning word discarded (DROP), next MemAddr=0040, next IROut has PCOut=0040.
- Redirect and IRWrite in the same cycle with FIFO non-empty -> IR unchanged, IRValid=0, FIFO empty.
- Wrap: RedirectAddr=16'hFFFF, two fetches -> MemAddr sequence FFFF then 0000; with IR_IMM_DECODE_EN, IROut=16'hAF00 -> ImmSext=FF00, ImmZext=0F00, ShiftOp=11.

Source files
------------

// File: rtl/jala_pkg.sv
// Shared types for the instruction fetch path: opcode constants, fetch FSM
// states and the buffered fetch entry.
package jala_pkg;

  localparam int JALA_ADDR_W = 16;
  localparam int JALA_DATA_W = 16;

  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [JALA_ADDR_W-1:0] addr;
    logic [JALA_DATA_W-1:0] data;
  } fetch_entry_t;

  function automatic logic [1:0] shift_op(input logic [3:0] opc);
    case (opc)
      OP_SLL:  shift_op = 2'b01;
      OP_SRL:  shift_op = 2'b10;
      OP_SRA:  shift_op = 2'b11;
      default: shift_op = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {addr,data} entries; clear has priority over push/pop.
module fetch_fifo
  import jala_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  input  fetch_entry_t           wdata_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;

  // Storage needs no reset: only entries below count_q are ever read.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/ir_fetch_unit.sv
// Instruction fetch + IR: one outstanding memory request, prefetch FIFO,
// redirect flush. Define IR_IMM_DECODE_EN to add registered immediate/shift decode.
module ir_fetch_unit
  import jala_pkg::*;
#(
  parameter int              ADDR_W   = JALA_ADDR_W,
  parameter int              DATA_W   = JALA_DATA_W,
  parameter int              DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemReq,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemRdData,
  input  logic              IRWrite,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectAddr,
  output logic [DATA_W-1:0] IROut,
  output logic [ADDR_W-1:0] PCOut,
  output logic              IRValid,
  output logic              Stall
`ifdef IR_IMM_DECODE_EN
  ,
  output logic [15:0]       ImmZext,
  output logic [15:0]       ImmSext,
  output logic [1:0]        ShiftOp
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fetch_pc_q, mem_addr_q;
  logic              mem_req_q;
  logic [DATA_W-1:0] ir_q;
  logic [ADDR_W-1:0] pc_q;
  logic              irv_q;

  logic              push, pop, fifo_empty;
  logic [CW-1:0]     fifo_cnt;
  fetch_entry_t      wr_entry, head;

  // Redirect suppresses both push and pop; the FIFO is cleared that edge anyway.
  assign push     = (state_q == WAIT) && MemAck && !Redirect;
  assign pop      = IRWrite && !fifo_empty && !Redirect;
  assign Stall    = IRWrite && fifo_empty;
  assign wr_entry = '{addr: fetch_pc_q, data: MemRdData};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (Redirect),
    .wdata_i (wr_entry),
    .head_o  (head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty)
  );

  // Issue only from IDLE (nothing outstanding), so count < DEPTH reserves the slot.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
    end else begin
      mem_req_q <= 1'b0;
      if (Redirect) begin
        fetch_pc_q <= RedirectAddr;
        if ((state_q == WAIT || state_q == DROP) && !MemAck) state_q <= DROP;
        else                                                  state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (fifo_cnt < CW'(DEPTH)) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= fetch_pc_q;
            state_q    <= WAIT;
          end
          WAIT: if (MemAck) begin
            fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
            state_q    <= IDLE;
          end
          DROP: if (MemAck) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign MemReq  = mem_req_q;
  assign MemAddr = mem_addr_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ir_q  <= '0;
      pc_q  <= '0;
      irv_q <= 1'b0;
    end else if (Redirect) begin
      irv_q <= 1'b0;
    end else if (pop) begin
      ir_q  <= head.data;
      pc_q  <= head.addr;
      irv_q <= 1'b1;
    end
  end

  assign IROut   = ir_q;
  assign PCOut   = pc_q;
  assign IRValid = irv_q;

`ifdef IR_IMM_DECODE_EN
  logic [15:0] imm_zext_q, imm_sext_q;
  logic [1:0]  shift_op_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      imm_zext_q <= '0;
      imm_sext_q <= '0;
      shift_op_q <= '0;
    end else if (pop && !Redirect) begin
      imm_zext_q <= {4'b0, head.data[11:0]};
      imm_sext_q <= {{4{head.data[11]}}, head.data[11:0]};
      shift_op_q <= shift_op(head.data[15:12]);
    end
  end

  assign ImmZext = imm_zext_q;
  assign ImmSext = imm_sext_q;
  assign ShiftOp = shift_op_q;
`endif

endmodule

// File: tb/tb_ir_fetch_unit.sv
// Directed bench for ir_fetch_unit with a behavioural single-outstanding memory.
module tb_ir_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] MemAddr;
  logic        MemReq;
  logic        MemAck = 1'b0;
  logic [15:0] MemRdData = '0;
  logic        IRWrite = 1'b0;
  logic        Redirect = 1'b0;
  logic [15:0] RedirectAddr = '0;
  logic [15:0] IROut;
  logic [15:0] PCOut;
  logic        IRValid;
  logic        Stall;
`ifdef IR_IMM_DECODE_EN
  logic [15:0] ImmZext, ImmSext;
  logic [1:0]  ShiftOp;
`endif

  int checks = 0;
  int errors = 0;

  int          lat = 2;
  int          req_cnt = 0;
  int          ack_cnt = 0;
  logic [15:0] req_addr [0:15];
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [15:0] paddr = '0;

  ir_fetch_unit dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .MemAddr      (MemAddr),
    .MemReq       (MemReq),
    .MemAck       (MemAck),
    .MemRdData    (MemRdData),
    .IRWrite      (IRWrite),
    .Redirect     (Redirect),
    .RedirectAddr (RedirectAddr),
    .IROut        (IROut),
    .PCOut        (PCOut),
    .IRValid      (IRValid),
    .Stall        (Stall)
`ifdef IR_IMM_DECODE_EN
    ,
    .ImmZext      (ImmZext),
    .ImmSext      (ImmSext),
    .ShiftOp      (ShiftOp)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: mem_word = 16'h8003;
      16'h0001: mem_word = 16'h9005;
      16'h0002: mem_word = 16'h1234;
      16'h0040: mem_word = 16'h4040;
      16'h0041: mem_word = 16'h4141;
      16'hFFFF: mem_word = 16'hAF00;
      default:  mem_word = a ^ 16'hA5A5;
    endcase
  endfunction

  // Memory: sees MemReq just after an edge, answers lat cycles later for one cycle.
  always @(posedge CLK) begin
    #1;
    if (!RST_N) begin
      MemAck  = 1'b0;
      pend    = 1'b0;
      cnt     = 0;
      req_cnt = 0;
      ack_cnt = 0;
    end else begin
      MemAck = 1'b0;
      if (pend) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          MemAck    = 1'b1;
          MemRdData = mem_word(paddr);
          ack_cnt   = ack_cnt + 1;
          pend      = 1'b0;
        end
      end
      if (MemReq) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = MemAddr;
        if (req_cnt < 16) req_addr[req_cnt] = MemAddr;
        req_cnt = req_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST_N    = 1'b0;
    IRWrite  = 1'b0;
    Redirect = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_acks(input int n, input string tag);
    for (int i = 0; i < 100 && ack_cnt < n; i++) tick();
    check(tag, 32'(ack_cnt >= n), 32'd1);
  endtask

  task automatic wait_reqs(input int n, input string tag);
    for (int i = 0; i < 100 && req_cnt < n; i++) tick();
    check(tag, 32'(req_cnt >= n), 32'd1);
  endtask

  task automatic pulse_irwrite();
    IRWrite = 1'b1;
    #1;
    check("no_stall_on_pop", 32'(Stall), 32'd0);
    tick();
    IRWrite = 1'b0;
  endtask

  initial begin
    // Reset values and basic in-order fetch
    lat = 2;
    do_reset();
    check("rst_irout",   32'(IROut),   32'h0);
    check("rst_pcout",   32'(PCOut),   32'h0);
    check("rst_irvalid", 32'(IRValid), 32'h0);
    check("rst_memreq",  32'(MemReq),  32'h0);
    check("rst_memaddr", 32'(MemAddr), 32'h0);
    check("rst_stall",   32'(Stall),   32'h0);
    RST_N = 1'b1;
    wait_acks(1, "t1_ack0_timeout");
    tick();
    pulse_irwrite();
    check("t1_ir0", 32'(IROut),   32'h8003);
    check("t1_pc0", 32'(PCOut),   32'h0000);
    check("t1_v0",  32'(IRValid), 32'h1);
`ifdef IR_IMM_DECODE_EN
    check("t1_shop0", 32'(ShiftOp), 32'h1);
    check("t1_zext0", 32'(ImmZext), 32'h0003);
`endif
    wait_acks(2, "t1_ack1_timeout");
    tick();
    pulse_irwrite();
    check("t1_ir1", 32'(IROut),   32'h9005);
    check("t1_pc1", 32'(PCOut),   32'h0001);
    check("t1_v1",  32'(IRValid), 32'h1);
`ifdef IR_IMM_DECODE_EN
    check("t1_shop1", 32'(ShiftOp), 32'h2);
`endif

    // IRWrite held from reset, 3-cycle memory: stall until first word is buffered
    lat = 3;
    do_reset();
    RST_N   = 1'b1;
    IRWrite = 1'b1;
    #1;
    check("t2_stall_init", 32'(Stall), 32'h1);
    for (int i = 0; i < 20 && ack_cnt == 0; i++) begin
      tick();
      if (ack_cnt == 0) check("t2_stall_wait", 32'(Stall), 32'h1);
    end
    check("t2_ir_at_ack", 32'(IROut), 32'h0);
    tick();
    check("t2_ir_buffered", 32'(IROut), 32'h0);
    check("t2_stall_clear", 32'(Stall), 32'h0);
    tick();
    IRWrite = 1'b0;
    check("t2_ir",  32'(IROut),   32'h8003);
    check("t2_pc",  32'(PCOut),   32'h0000);
    check("t2_v",   32'(IRValid), 32'h1);

    // FIFO fill: exactly DEPTH requests without consumption
    lat = 2;
    do_reset();
    RST_N = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("t3_reqs",   32'(req_cnt),     32'd2);
    check("t3_addr0",  32'(req_addr[0]), 32'h0000);
    check("t3_addr1",  32'(req_addr[1]), 32'h0001);
    check("t3_req_lo", 32'(MemReq),      32'h0);

    // Redirect while the request for address 2 is outstanding
    do_reset();
    RST_N = 1'b1;
    wait_acks(2, "t4_fill_timeout");
    tick();
    pulse_irwrite();
    wait_reqs(3, "t4_req2_timeout");
    check("t4_addr2", 32'(MemAddr), 32'h0002);
    Redirect     = 1'b1;
    RedirectAddr = 16'h0040;
    tick();
    Redirect = 1'b0;
    check("t4_irv_clr",  32'(IRValid), 32'h0);
    check("t4_ir_hold",  32'(IROut),   32'h8003);
    wait_reqs(4, "t4_req40_timeout");
    check("t4_req40", 32'(req_addr[3]), 32'h0040);
    wait_acks(4, "t4_ack40_timeout");
    tick();
    pulse_irwrite();
    check("t4_ir40", 32'(IROut),   32'h4040);
    check("t4_pc40", 32'(PCOut),   32'h0040);
    check("t4_v40",  32'(IRValid), 32'h1);

    // Redirect and IRWrite together with a non-empty FIFO
    do_reset();
    RST_N = 1'b1;
    wait_acks(2, "t5_fill_timeout");
    tick();
    pulse_irwrite();
    wait_acks(3, "t5_refill_timeout");
    tick();
    IRWrite      = 1'b1;
    Redirect     = 1'b1;
    RedirectAddr = 16'h0100;
    tick();
    Redirect = 1'b0;
    #1;
    check("t5_ir_hold",  32'(IROut),   32'h8003);
    check("t5_pc_hold",  32'(PCOut),   32'h0000);
    check("t5_irv_clr",  32'(IRValid), 32'h0);
    check("t5_empty",    32'(Stall),   32'h1);
    IRWrite = 1'b0;

    // Fetch address wrap FFFF -> 0000
    do_reset();
    RST_N        = 1'b1;
    Redirect     = 1'b1;
    RedirectAddr = 16'hFFFF;
    tick();
    Redirect = 1'b0;
    wait_reqs(2, "t6_req_timeout");
    check("t6_addr0", 32'(req_addr[0]), 32'hFFFF);
    check("t6_addr1", 32'(req_addr[1]), 32'h0000);
    wait_acks(1, "t6_ack_timeout");
    tick();
    pulse_irwrite();
    check("t6_ir", 32'(IROut), 32'hAF00);
    check("t6_pc", 32'(PCOut), 32'hFFFF);
`ifdef IR_IMM_DECODE_EN
    check("t6_sext", 32'(ImmSext), 32'hFF00);
    check("t6_zext", 32'(ImmZext), 32'h0F00);
    check("t6_shop", 32'(ShiftOp), 32'h3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
